// File: rtl/lr_check_sequencer_pkg.sv
// Shared definitions for the left/right disparity check path: sequencer
// state encoding, line-buffer geometry defaults and check-engine latency.
package lr_check_sequencer_pkg;

   localparam int DEF_AWIDTH = 9;
   localparam int DEF_DEPTH  = 512;
   localparam int DEF_DRAIN  = 3;
   localparam int DIM_W      = 11;

   typedef logic [DIM_W-1:0] dim_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_ROW,
      ST_SCAN,
      ST_DRAIN,
      ST_ROW_END
   } seq_state_e;

   // True when a zero-based index has reached the final position of a
   // one-based extent (column within width, row within height).
   function automatic logic is_last(input dim_t idx, input dim_t extent);
      return idx == (extent - dim_t'(1));
   endfunction

endpackage

// File: rtl/lr_check_sequencer_if.sv
// Control/read bundle between the line-buffer sequencer and its parent.
// master: the sequencer (issues reads, reports progress).
// slave : the parent (frame geometry, start, row availability, backpressure).
interface lr_check_sequencer_if
   import lr_check_sequencer_pkg::*;
#(
   parameter int AWIDTH = DEF_AWIDTH
) ();

   logic              start;
   dim_t              img_width;
   dim_t              img_height;
   logic              row_ready;
   logic              stall;
   logic [AWIDTH-1:0] rd_addr_align;
   logic              rd_en_align;
   logic              clken;
   logic              row_done;
   logic              frame_done;
   logic              busy;
   dim_t              row_cnt;

   modport master (
      input  start, img_width, img_height, row_ready, stall,
      output rd_addr_align, rd_en_align, clken, row_done, frame_done, busy, row_cnt
   );

   modport slave (
      output start, img_width, img_height, row_ready, stall,
      input  rd_addr_align, rd_en_align, clken, row_done, frame_done, busy, row_cnt
   );

endinterface

// File: rtl/lr_check_sequencer.sv
// Row sequencer for the L/R consistency check. Walks the disp_L align buffer
// one row at a time with a free-running circular read pointer, then keeps the
// check engine clocked for its pipeline latency before reporting the row.
// Every output is a register: the value visible in a cycle is the step the
// sequencer decided on at the preceding edge, so stall sampled at an edge
// turns the following cycle into an idle bubble.
module lr_check_sequencer
   import lr_check_sequencer_pkg::*;
#(
   parameter int AWIDTH = DEF_AWIDTH,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int DRAIN  = DEF_DRAIN
) (
   input  logic                  clk,
   input  logic                  rst,
   lr_check_sequencer_if.master  bus
);

   localparam int                DCW        = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [AWIDTH-1:0] ADDR_LAST  = AWIDTH'(DEPTH - 1);
   localparam logic [DCW-1:0]    DRAIN_LAST = DCW'(DRAIN - 1);

   seq_state_e        state, state_n;
   dim_t              col_cnt, col_n;
   dim_t              row_n;
   logic [DCW-1:0]    drain_cnt, drain_n;
   logic [AWIDTH-1:0] addr_n, addr_inc;
   logic              rd_en_n, clken_n, row_done_n, frame_done_n, busy_n;

   // The pointer wraps at the buffer depth and never rewinds between rows.
   assign addr_inc = (bus.rd_addr_align == ADDR_LAST) ? '0 : bus.rd_addr_align + AWIDTH'(1);

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_n;
   end

   // Next state, next counters and next output values; stall freezes all.
   // NOTE: every signal gets a default before the case so no path leaves a
   // variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_n      = state;
      col_n        = col_cnt;
      drain_n      = drain_cnt;
      row_n        = bus.row_cnt;
      addr_n       = bus.rd_addr_align;
      rd_en_n      = 1'b1;
      clken_n      = 1'b0;
      row_done_n   = 1'b0;
      frame_done_n = 1'b0;
      if (!bus.stall) begin
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  state_n = ST_WAIT_ROW;
                  row_n   = '0;
               end
            end
            ST_WAIT_ROW: begin
               if (bus.row_ready) begin
                  state_n = ST_SCAN;
                  col_n   = '0;
                  rd_en_n = 1'b0;
                  clken_n = 1'b1;
               end
            end
            ST_SCAN: begin
               // The cycle just shown was a read: step the pointer past it.
               addr_n  = addr_inc;
               clken_n = 1'b1;
               if (is_last(col_cnt, bus.img_width)) begin
                  state_n = ST_DRAIN;
                  drain_n = '0;
               end else begin
                  col_n   = col_cnt + dim_t'(1);
                  rd_en_n = 1'b0;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state_n      = ST_ROW_END;
                  row_done_n   = 1'b1;
                  frame_done_n = is_last(bus.row_cnt, bus.img_height);
               end else begin
                  drain_n = drain_cnt + DCW'(1);
                  clken_n = 1'b1;
               end
            end
            ST_ROW_END: begin
               if (is_last(bus.row_cnt, bus.img_height)) begin
                  state_n = ST_IDLE;
               end else begin
                  state_n = ST_WAIT_ROW;
                  row_n   = bus.row_cnt + dim_t'(1);
               end
            end
            default: state_n = ST_IDLE;
         endcase
      end
      busy_n = (state_n != ST_IDLE);
   end

   // Counters, read pointer and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         col_cnt           <= '0;
         drain_cnt         <= '0;
         bus.row_cnt       <= '0;
         bus.rd_addr_align <= '0;
         bus.rd_en_align   <= 1'b1;
         bus.clken         <= 1'b0;
         bus.row_done      <= 1'b0;
         bus.frame_done    <= 1'b0;
         bus.busy          <= 1'b0;
      end else begin
         col_cnt           <= col_n;
         drain_cnt         <= drain_n;
         bus.row_cnt       <= row_n;
         bus.rd_addr_align <= addr_n;
         bus.rd_en_align   <= rd_en_n;
         bus.clken         <= clken_n;
         bus.row_done      <= row_done_n;
         bus.frame_done    <= frame_done_n;
         bus.busy          <= busy_n;
      end
   end

endmodule

// File: doc/lr_check_sequencer.md
LR_CHECK_SEQUENCER -- requirements
Module: lr_check_sequencer

Interface
REQ-001 Parameter AWIDTH, default 9, SHALL set the address width of the disparity line buffers.
REQ-002 Parameter DEPTH, default 512, SHALL set the circular line-buffer depth, equal to 2**AWIDTH.
REQ-003 Parameter DRAIN, default 3, SHALL set the downstream check-engine pipeline latency in cycles.
REQ-004 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 rst  in  1  reset; synchronous and active-low.
REQ-006 start  in  1  one-cycle pulse that begins a frame; ignored unless in IDLE.
REQ-007 img_width  in  11  pixels per row; legal range 1..DEPTH.
REQ-008 img_height  in  11  rows per frame; legal range 1..2047.
REQ-009 row_ready  in  1  high when the align buffer and column buffer both hold a complete row.
REQ-010 stall  in  1  downstream backpressure; while high, the sequencer freezes.
REQ-011 rd_addr_align  out  AWIDTH  read address for the disp_L align buffer.
REQ-012 rd_en_align  out  1  read enable for the disp_L align buffer; active-low, 0 = read.
REQ-013 clken  out  1  clock enable for the check engine.
REQ-014 row_done  out  1  one-cycle pulse when a row has fully drained.
REQ-015 frame_done  out  1  one-cycle pulse after the last row drains.
REQ-016 busy  out  1  high in every state other than IDLE.
REQ-017 row_cnt  out  11  index of the current row, starting at 0.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_ROW, SCAN, DRAIN and ROW_END.
REQ-019 IDLE -> WAIT_ROW on start; row_cnt SHALL be cleared to 0 on that transition.
REQ-020 WAIT_ROW -> SCAN when row_ready=1.
REQ-021 SCAN SHALL issue exactly img_width reads, one per non-stalled cycle: rd_en_align=0, clken=1, and rd_addr_align incremented by 1 after each read.
REQ-022 rd_addr_align SHALL wrap modulo DEPTH (DEPTH-1 -> 0) and SHALL NOT reset between rows or frames; the pointer is continuous across rows.
REQ-023 When the column counter reaches img_width-1 on a read, the FSM SHALL move SCAN -> DRAIN on the next cycle.
REQ-024 DRAIN SHALL hold rd_en_align=1 and clken=1 for exactly DRAIN non-stalled cycles, then move to ROW_END.
REQ-025 ROW_END SHALL last one cycle and pulse row_done=1.
REQ-026 If row_cnt == img_height-1 in ROW_END, the FSM SHALL pulse frame_done=1 in the same cycle, then go to IDLE; otherwise it SHALL increment row_cnt and go to WAIT_ROW.
REQ-027 In IDLE and WAIT_ROW, outputs SHALL be rd_en_align=1 and clken=0.
REQ-028 While stall=1 in any state, the sequencer SHALL:
  - drive clken=0 and rd_en_align=1;
  - hold all counters, the address and the state;
  - not advance the DRAIN counter.
REQ-029 stall SHALL take precedence over row_ready and over counter terminal conditions.
REQ-030 start asserted while busy=1 SHALL be ignored, with no effect on state.
REQ-031 With img_width=1, SCAN SHALL last exactly one non-stalled cycle.
REQ-032 With img_height=1, frame_done SHALL pulse coincident with the first row_done.
REQ-033 Latency SHALL be one cycle from row_ready sampled high in WAIT_ROW to the first rd_en_align=0.
REQ-034 All outputs SHALL be registered.

Reset
REQ-035 On rst=0 at a clock edge, the following SHALL take these values:
  - state = IDLE
  - rd_addr_align = 0
  - rd_en_align = 1
  - clken = 0
  - row_done = 0, frame_done = 0, busy = 0
  - row_cnt = 0
  - column and drain counters = 0
REQ-036 Reset asserted mid-frame SHALL abandon the frame with no row_done or frame_done pulse.

Structure
REQ-037 The FSM state encoding, DEPTH/AWIDTH defaults and the DRAIN latency constant SHALL reside in the shared postprocessing package, so the check engine and this sequencer agree on them.
REQ-038 The block SHALL be a single module with no sub-modules; the check engine SHALL be instantiated beside it by the parent.

Verification
REQ-039 Nominal frame: img_width=8, img_height=2, row_ready=1, no stall. Required:
  - addresses 0..7 for row 0, then 8..15 for row 1;
  - each row has 8 cycles with rd_en_align=0, then 3 drain cycles;
  - row_done pulses 2 times, then frame_done pulses 1 time, coincident with the second row_done.
REQ-040 Wrap-around: preload the pointer to 510 via prior frames, img_width=4. Required: addresses 510, 511, 0, 1.
REQ-041 Stall: stall high for 5 cycles at column 3 of width 8. Required:
  - no address advance and clken=0 during the stall;
  - the total read count is still 8;
  - a stall held during DRAIN extends DRAIN by the stall length.
REQ-042 row_ready gating: row_ready held low 10 cycles after start. Required: the FSM stays in WAIT_ROW with clken=0; the first read occurs 1 cycle after row_ready rises.
REQ-043 Reset mid-SCAN: at column 5 of row 1, assert rst. Required:
  - all outputs reach their reset values on the next edge;
  - no frame_done pulse occurs;
  - a new start restarts at row_cnt=0 and address 0.
REQ-044 Degenerate sizes: img_width=1, img_height=1. Required: exactly 1 read, 3 drain cycles, and row_done and frame_done coincident.
